// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and helpers for the sequenced ALU.
package alu_pkg;

  localparam int unsigned OpW = 4;

  localparam logic [OpW-1:0] OpAdd  = 4'b0000;
  localparam logic [OpW-1:0] OpAnd  = 4'b0001;
  localparam logic [OpW-1:0] OpOr   = 4'b0010;
  localparam logic [OpW-1:0] OpXor  = 4'b0011;
  localparam logic [OpW-1:0] OpSll  = 4'b0100;
  localparam logic [OpW-1:0] OpSrl  = 4'b0101;
  localparam logic [OpW-1:0] OpSub  = 4'b0110;
  localparam logic [OpW-1:0] OpSra  = 4'b0111;
  localparam logic [OpW-1:0] OpMul  = 4'b1001;
  localparam logic [OpW-1:0] OpMulh = 4'b1010;
  localparam logic [OpW-1:0] OpDiv  = 4'b1011;
  localparam logic [OpW-1:0] OpRem  = 4'b1100;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } alu_state_e;

  function automatic logic is_iter(input logic [OpW-1:0] op);
    return op inside {OpMul, OpMulh, OpDiv, OpRem};
  endfunction

  function automatic logic is_mul(input logic [OpW-1:0] op);
    return op inside {OpMul, OpMulh};
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between the execute stage and the ALU.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) ();

  logic            flush;
  logic            req_vld;
  logic            req_rdy;
  logic [OpW-1:0]  cntr;
  logic            not_s;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic [SHW-1:0]  shamt;
  logic            res_vld;
  logic            res_rdy;
  logic [XLEN-1:0] resalt;
  logic [1:0]      cnd;

  modport master (
    output flush, req_vld, cntr, not_s, srca, srcb, shamt, res_rdy,
    input  req_rdy, res_vld, resalt, cnd
  );

  modport slave (
    input  flush, req_vld, cntr, not_s, srca, srcb, shamt, res_rdy,
    output req_rdy, res_vld, resalt, cnd
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative unit: shift-add multiply and restoring divide on magnitudes,
// one step per cycle for XLEN cycles, with sign fix-up applied to the final step.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [OpW-1:0]  op_i,
  input  logic            not_s_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(XLEN);

  logic            run_q, run_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [OpW-1:0]  op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, mag_q, mag_d, a_q, a_d;
  logic            neg_q, neg_d, negr_q, negr_d, bzero_q, bzero_d;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, hi_nx, lo_nx;
  logic [XLEN:0]   sum, shifted, diff;
  logic [2*XLEN-1:0] prod_fix;

  assign a_neg = !not_s_i && a_i[XLEN-1];
  assign b_neg = !not_s_i && b_i[XLEN-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // Multiply: hi accumulates, lo holds the multiplier and shifts into product low half.
  // Divide:   hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, mag_q};
    if (is_mul(op_q)) begin
      {hi_nx, lo_nx} = {sum, lo_q[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      hi_nx = diff[XLEN-1:0];
      lo_nx = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_nx = shifted[XLEN-1:0];
      lo_nx = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
    case (op_q)
      OpMul:   result_o = prod_fix[XLEN-1:0];
      OpMulh:  result_o = prod_fix[2*XLEN-1:XLEN];
      OpDiv:   result_o = bzero_q ? '1 : (neg_q ? -lo_nx : lo_nx);
      OpRem:   result_o = bzero_q ? a_q : (negr_q ? -hi_nx : hi_nx);
      default: result_o = '0;
    endcase
  end

  assign done_o = run_q && (cnt_q == '0);

  always_comb begin
    run_d   = run_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mag_d   = mag_q;
    a_d     = a_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    bzero_d = bzero_q;
    if (flush_i) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start_i) begin
      run_d   = 1'b1;
      cnt_d   = CntW'(XLEN - 1);
      op_d    = op_i;
      hi_d    = '0;
      lo_d    = is_mul(op_i) ? b_mag : a_mag;
      mag_d   = is_mul(op_i) ? a_mag : b_mag;
      a_d     = a_i;
      neg_d   = a_neg ^ b_neg;
      negr_d  = a_neg;
      bzero_d = (b_i == '0);
    end else if (run_q) begin
      hi_d = hi_nx;
      lo_d = lo_nx;
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mag_q   <= '0;
      a_q     <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      bzero_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mag_q   <= mag_d;
      a_q     <= a_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      bzero_q <= bzero_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: registered single-cycle ops, iterative mul/div,
// and a condition vector for branch resolution.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] resalt_q, resalt_d, a_q, a_d, b_q, b_d;
  logic            ns_q, ns_d;
  logic [1:0]      cnd_q, cnd_d;
  logic            it_start, it_done;
  logic [XLEN-1:0] it_result, single_res;
  logic [SHW-1:0]  sh;

  function automatic logic [1:0] cnd_of(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                        input logic ns);
    logic lt;
    lt = ns ? (a < b) : ($signed(a) < $signed(b));
    return {lt, a == b};
  endfunction

  assign sh = bus.shamt;

  always_comb begin
    case (bus.cntr)
      OpAdd:   single_res = bus.srca + bus.srcb;
      OpAnd:   single_res = bus.srca & bus.srcb;
      OpOr:    single_res = bus.srca | bus.srcb;
      OpXor:   single_res = bus.srca ^ bus.srcb;
      OpSll:   single_res = bus.srca << sh;
      OpSrl:   single_res = bus.srca >> sh;
      OpSub:   single_res = bus.srca - bus.srcb;
      OpSra:   single_res = $unsigned($signed(bus.srca) >>> sh);
      default: single_res = '0;
    endcase
  end

  alu_muldiv_iter #(
    .XLEN(XLEN)
  ) u_iter (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (bus.flush),
    .start_i (it_start),
    .op_i    (bus.cntr),
    .not_s_i (bus.not_s),
    .a_i     (bus.srca),
    .b_i     (bus.srcb),
    .done_o  (it_done),
    .result_o(it_result)
  );

  // Result and cnd registers are zero whenever no result is being offered.
  always_comb begin
    state_d  = state_q;
    resalt_d = resalt_q;
    cnd_d    = cnd_q;
    a_d      = a_q;
    b_d      = b_q;
    ns_d     = ns_q;
    it_start = 1'b0;
    if (bus.flush) begin
      state_d  = StIdle;
      resalt_d = '0;
      cnd_d    = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_vld) begin
            a_d  = bus.srca;
            b_d  = bus.srcb;
            ns_d = bus.not_s;
            if (is_iter(bus.cntr)) begin
              it_start = 1'b1;
              state_d  = StBusy;
            end else begin
              state_d  = StDone;
              resalt_d = single_res;
              cnd_d    = cnd_of(bus.srca, bus.srcb, bus.not_s);
            end
          end
        end
        StBusy: begin
          if (it_done) begin
            state_d  = StDone;
            resalt_d = it_result;
            cnd_d    = cnd_of(a_q, b_q, ns_q);
          end
        end
        StDone: begin
          if (bus.res_rdy) begin
            state_d  = StIdle;
            resalt_d = '0;
            cnd_d    = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      resalt_q <= '0;
      cnd_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ns_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      resalt_q <= resalt_d;
      cnd_q    <= cnd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ns_q     <= ns_d;
    end
  end

  assign bus.req_rdy = (state_q == StIdle);
  assign bus.res_vld = (state_q == StDone);
  assign bus.resalt  = resalt_q;
  assign bus.cnd     = cnd_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against a native-arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.XLEN(XLEN)) bus ();

  alu_seq #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] last_res;
  logic [1:0]  last_cnd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_res(input logic [3:0] op, input logic ns,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: return a + b;
      4'd1: return a & b;
      4'd2: return a | b;
      4'd3: return a ^ b;
      4'd4: return a << sh;
      4'd5: return a >> sh;
      4'd6: return a - b;
      4'd7: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd9, 4'd10: begin
        p = ns ? ({32'h0, a} * {32'h0, b}) : 64'(sa * sb);
        return (op == 4'd9) ? p[31:0] : p[63:32];
      end
      4'd11: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return ns ? a / b : 32'(sa / sb);
      end
      4'd12: begin
        if (b == 0) return a;
        return ns ? a % b : 32'(sa % sb);
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] model_cnd(input logic [31:0] a, input logic [31:0] b,
                                           input logic ns);
    longint sa, sb;
    sa = ns ? longint'({32'h0, a}) : longint'($signed(a));
    sb = ns ? longint'({32'h0, b}) : longint'($signed(b));
    return {sa < sb, sa == sb};
  endfunction

  task automatic wait_rdy();
    int n = 0;
    while (!bus.req_rdy && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) check_eq("req_rdy_timeout", 64'(bus.req_rdy), 64'd1);
  endtask

  task automatic do_op(input logic [3:0] op, input logic ns, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input int hold,
                       input bit pulse, input string tag);
    logic [31:0] er;
    logic [1:0]  ec;
    int lat, elat;
    er   = model_res(op, ns, a, b, sh);
    ec   = model_cnd(a, b, ns);
    elat = (op inside {4'd9, 4'd10, 4'd11, 4'd12}) ? XLEN : 0;
    wait_rdy();
    bus.req_vld = 1'b1;
    bus.cntr    = op;
    bus.not_s   = ns;
    bus.srca    = a;
    bus.srcb    = b;
    bus.shamt   = sh;
    bus.res_rdy = (hold == 0);
    tick();
    bus.req_vld = 1'b0;
    bus.cntr    = 4'($urandom());
    bus.not_s   = 1'($urandom());
    bus.srca    = $urandom();
    bus.srcb    = $urandom();
    bus.shamt   = 5'($urandom());
    lat = 0;
    while (!bus.res_vld && lat < 100) begin
      tick();
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(elat));
    check_eq({tag, "_res"}, 64'(bus.resalt), 64'(er));
    check_eq({tag, "_cnd"}, 64'(bus.cnd), 64'(ec));
    last_res = bus.resalt;
    last_cnd = bus.cnd;
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        check_eq({tag, "_hold_res"}, 64'(bus.resalt), 64'(er));
        check_eq({tag, "_hold_cnd"}, 64'(bus.cnd), 64'(ec));
        check_eq({tag, "_hold_rdy"}, 64'(bus.req_rdy), 64'd0);
        check_eq({tag, "_hold_vld"}, 64'(bus.res_vld), 64'd1);
        bus.req_vld = (i >= 2 && i < 5);
        bus.cntr    = OpAdd;
      end
      tick();
    end
    bus.req_vld = 1'b0;
    bus.res_rdy = 1'b1;
    tick();
    check_eq({tag, "_post_vld"}, 64'(bus.res_vld), 64'd0);
    check_eq({tag, "_post_rdy"}, 64'(bus.req_rdy), 64'd1);
    if (pulse) begin
      check_eq({tag, "_post_cnd"}, 64'(bus.cnd), 64'd0);
      tick();
      check_eq({tag, "_no_extra"}, 64'(bus.res_vld), 64'd0);
    end
    bus.res_rdy = 1'($urandom());
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [3:0]  op;
    logic [31:0] a, b;
    bus.flush   = 1'b0;
    bus.req_vld = 1'b0;
    bus.cntr    = '0;
    bus.not_s   = 1'b0;
    bus.srca    = '0;
    bus.srcb    = '0;
    bus.shamt   = '0;
    bus.res_rdy = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    check_eq("rst_req_rdy", 64'(bus.req_rdy), 64'd1);
    check_eq("rst_res_vld", 64'(bus.res_vld), 64'd0);
    check_eq("rst_resalt", 64'(bus.resalt), 64'd0);
    check_eq("rst_cnd", 64'(bus.cnd), 64'd0);
    rst = 1'b0;
    tick();

    do_op(OpAdd, 1'b0, 32'd5, 32'd5, 5'd0, 0, 1'b0, "add");
    check_eq("add_k", 64'(last_res), 64'd10);
    check_eq("add_cnd_k", 64'(last_cnd), 64'b01);
    do_op(OpSra, 1'b0, 32'hFFFF_FFFB, 32'd0, 5'd1, 0, 1'b0, "sra");
    check_eq("sra_k", 64'(last_res), 64'hFFFF_FFFD);
    do_op(OpSrl, 1'b0, 32'hFFFF_FFFB, 32'd0, 5'd1, 0, 1'b0, "srl");
    check_eq("srl_k", 64'(last_res), 64'h7FFF_FFFD);
    do_op(OpSub, 1'b0, 32'd1, 32'd5, 5'd0, 0, 1'b0, "sub");
    check_eq("sub_k", 64'(last_res), 64'hFFFF_FFFC);
    check_eq("sub_cnd_k", 64'(last_cnd), 64'b10);
    do_op(OpMul, 1'b0, -32'sd3, 32'd7, 5'd0, 0, 1'b0, "mul");
    check_eq("mul_k", 64'(last_res), 64'hFFFF_FFEB);
    do_op(OpMulh, 1'b0, -32'sd3, 32'd7, 5'd0, 0, 1'b0, "mulh");
    check_eq("mulh_k", 64'(last_res), 64'hFFFF_FFFF);
    do_op(OpMulh, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 0, 1'b0, "mulhu");
    check_eq("mulhu_k", 64'(last_res), 64'hFFFF_FFFE);
    do_op(OpDiv, 1'b0, -32'sd7, 32'd2, 5'd0, 0, 1'b0, "div");
    check_eq("div_k", 64'(last_res), 64'hFFFF_FFFD);
    do_op(OpRem, 1'b0, -32'sd7, 32'd2, 5'd0, 0, 1'b0, "rem");
    check_eq("rem_k", 64'(last_res), 64'hFFFF_FFFF);
    do_op(OpDiv, 1'b0, 32'd123, 32'd0, 5'd0, 0, 1'b0, "div0");
    check_eq("div0_k", 64'(last_res), 64'hFFFF_FFFF);
    do_op(OpRem, 1'b0, 32'd123, 32'd0, 5'd0, 0, 1'b0, "rem0");
    check_eq("rem0_k", 64'(last_res), 64'd123);
    do_op(OpDiv, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0, 1'b0, "divov");
    check_eq("divov_k", 64'(last_res), 64'h8000_0000);
    do_op(4'b1000, 1'b0, 32'd9, 32'd9, 5'd0, 0, 1'b0, "undef");
    check_eq("undef_k", 64'(last_res), 64'd0);

    do_op(OpXor, 1'b0, $urandom(), $urandom(), 5'd0, 10, 1'b1, "bp");

    // Flush ten cycles into a divide: no result may ever appear.
    wait_rdy();
    bus.req_vld = 1'b1;
    bus.cntr    = OpDiv;
    bus.srca    = 32'd1000;
    bus.srcb    = 32'd7;
    tick();
    bus.req_vld = 1'b0;
    repeat (10) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_eq("flush_rdy", 64'(bus.req_rdy), 64'd1);
    check_eq("flush_vld", 64'(bus.res_vld), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.res_vld) seen++;
      tick();
    end
    check_eq("flush_never_vld", 64'(seen), 64'd0);

    bus.flush   = 1'b1;
    bus.req_vld = 1'b1;
    bus.cntr    = OpAdd;
    tick();
    bus.flush   = 1'b0;
    bus.req_vld = 1'b0;
    check_eq("flush_req_rdy", 64'(bus.req_rdy), 64'd1);
    check_eq("flush_req_vld", 64'(bus.res_vld), 64'd0);

    // Asynchronous reset in the middle of a multiply.
    bus.req_vld = 1'b1;
    bus.cntr    = OpMul;
    bus.srca    = 32'd11;
    bus.srcb    = 32'd13;
    tick();
    bus.req_vld = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_req_rdy", 64'(bus.req_rdy), 64'd1);
    check_eq("arst_res_vld", 64'(bus.res_vld), 64'd0);
    check_eq("arst_resalt", 64'(bus.resalt), 64'd0);
    check_eq("arst_cnd", 64'(bus.cnd), 64'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.res_vld) seen++;
      tick();
    end
    check_eq("arst_never_vld", 64'(seen), 64'd0);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = pick();
      b  = ($urandom_range(0, 3) == 0) ? a : pick();
      do_op(op, 1'($urandom()), a, b, 5'($urandom()), $urandom_range(0, 2), 1'b0,
            $sformatf("rnd%0d_op%0h", i, op));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle CPU ALU.
- Registered single-cycle ops (ADD/SUB/logic/shifts) plus iterative radix-2 MUL/MULH/DIV/REM.
- Sits in the execute stage. The pipeline stalls on req_rdy/res_vld, and a redirect aborts work via flush.
- Produces a 2-bit condition vector cnd for branch resolution.

Parameters:
- XLEN, 32, datapath width (>=8, power of 2).
- SHW, $clog2(XLEN), shift-amount width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  abort any operation in progress, drop the held result
- req_vld  in  1  operation request valid
- req_rdy  out  1  block can accept a request
- cntr  in  4  opcode
- not_s  in  1  1 = operands unsigned (MULH/DIV/REM, cnd[1])
- srca  in  XLEN  operand A
- srcb  in  XLEN  operand B
- shamt  in  SHW  shift amount for SLL/SRL/SRA
- res_vld  out  1  result valid
- res_rdy  in  1  consumer accepts result
- resalt  out  XLEN  result
- cnd  out  2  [0] = srca==srcb, [1] = srca<srcb (signedness per not_s)

Behaviour:
- Opcodes:
  - ADD 0000, AND 0001, OR 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111.
  - MUL 1001 (low XLEN bits), MULH 1010 (high XLEN bits), DIV 1011, REM 1100.
  - 1000 and 1101-1111 are undefined: resalt=0, single-cycle timing.
- Reset: state=IDLE, req_rdy=1, res_vld=0, resalt=0, cnd=0. All internal registers are cleared.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: req_rdy=1. A request is accepted when req_vld=1 in IDLE. Operands, cntr, not_s and shamt are latched on accept.
  - Single-cycle op accepted at edge N: go to DONE. res_vld=1 after edge N, so resalt is visible in cycle N+1.
  - MUL/MULH/DIV/REM accepted at edge N: go to BUSY with counter=XLEN-1. Decrement once per cycle; go to DONE when counter==0. res_vld is visible after edge N+XLEN.
  - DONE: res_vld=1. resalt and cnd are stable until handshake. On res_rdy=1 go to IDLE.
  - req_rdy is 0 in BUSY and DONE. There is no overlap of result and new request.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - Shifts use shamt only. SRA replicates srca[XLEN-1].
- MUL/MULH:
  - Shift-add over XLEN iterations into a 2*XLEN accumulator.
  - Signed mode (not_s=0) multiplies magnitudes, then negates the product if signs differ.
- DIV/REM:
  - Restoring division on magnitudes. Signed quotient sign = sign(a) XOR sign(b). Remainder takes the sign of the dividend.
  - Divide by zero: quotient = all ones, remainder = srca. Still takes the full XLEN cycles.
  - Signed overflow (a = -2^(XLEN-1), b = -1): quotient = a, remainder = 0.
- cnd:
  - Computed from the latched operands for every op.
  - Registered together with resalt and valid only while res_vld=1; 0 otherwise.
- flush:
  - Synchronous; highest priority. Next state IDLE, res_vld=0, counter cleared.
  - A req_vld in the same cycle as flush is not accepted.
- Reset asserted mid-operation: immediate return to the reset values above. No partial result is output.
- cntr/srca/srcb changes after accept have no effect until the next accept.

Decomposition:
- Package alu_pkg: opcode localparams, FSM state encoding, helper function is_iter(op).
- Sub-module alu_muldiv_iter:
  - Inputs: start, op, not_s, a, b.
  - Outputs: done, result.
  - Owns the counter, accumulator and sign fix-up.
- The top level keeps the combinational single-cycle ops, cnd, the FSM and the handshake.

Test Plan:
1. Reset then ADD a=5, b=5 (XLEN=32), res_rdy=1 -> res_vld one cycle after accept, resalt=10, cnd=01; req_rdy back to 1 the following cycle.
2. SRA a=0xFFFFFFFB, shamt=1 -> resalt=0xFFFFFFFD. SRL same operands -> 0x7FFFFFFD. SUB a=1, b=5, not_s=0 -> resalt=0xFFFFFFFC, cnd=10.
3. MUL a=-3, b=7, not_s=0 -> res_vld exactly 32 cycles after accept, resalt=0xFFFFFFEB. MULH same -> 0xFFFFFFFF. MULH not_s=1, a=b=0xFFFFFFFF -> 0xFFFFFFFE.
4. DIV a=-7, b=2, not_s=0 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIV by 0 -> 0xFFFFFFFF; REM by 0 -> a. DIV 0x80000000 / -1 -> 0x80000000.
5. Backpressure: hold res_rdy=0 for 10 cycles after a result -> resalt/cnd stable, req_rdy=0 throughout. A req_vld pulse during this time is ignored.
6. flush at BUSY cycle 10 of a DIV -> IDLE next cycle, res_vld never asserts. Async rst mid-MUL -> all outputs at reset values within the same cycle.
